// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding and slice width for the nibble-serial adder
package cla_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/cla_seq_ctrl_if.sv
// cla_seq_ctrl_if: request/response bus of the nibble-serial adder
// CLA_SEQ_FLAGS_EN adds the zero/neg result flags.
interface cla_seq_ctrl_if #(parameter int WIDTH = 8);
  logic start_valid, start_ready, sub, busy, cout, overflow, done_valid, done_ready;
  logic [WIDTH-1:0] a, b, result;
`ifdef CLA_SEQ_FLAGS_EN
  logic zero, neg;
  modport master (output start_valid, a, b, sub, done_ready,
                  input start_ready, busy, result, cout, overflow, done_valid, zero, neg);
  modport slave (input start_valid, a, b, sub, done_ready,
                 output start_ready, busy, result, cout, overflow, done_valid, zero, neg);
`else
  modport master (output start_valid, a, b, sub, done_ready,
                  input start_ready, busy, result, cout, overflow, done_valid);
  modport slave (input start_valid, a, b, sub, done_ready,
                 output start_ready, busy, result, cout, overflow, done_valid);
`endif
endinterface

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead adder slice
module cla_4bit
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_o
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p[3:0] & c_i);
  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: WIDTH-bit add/sub computed one nibble per clock through a single CLA slice
// CLA_SEQ_FLAGS_EN adds registered zero/neg result flags.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  cla_seq_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NIBBLE_W-1:0] sum;
  logic slice_c, last;
`ifdef CLA_SEQ_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d;
`endif
  cla_4bit u_slice (
    .a_i(a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .b_i(b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .c_i(carry_q),
    .s_o(sum),
    .c_o(slice_c)
  );
  assign last = idx_q == IW'(NIBBLES - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
`ifdef CLA_SEQ_FLAGS_EN
    zero_d = zero_q;
    neg_d = neg_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start_valid) begin
        a_d = bus.a;
        b_d = bus.b ^ {WIDTH{bus.sub}};
        carry_d = bus.sub;
        idx_d = '0;
        res_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        res_d[NIBBLE_W*idx_q +: NIBBLE_W] = sum;
        carry_d = slice_c;
        idx_d = last ? idx_q : idx_q + 1'b1;
        if (last) begin
          cout_d = slice_c;
          // b_q already holds the inverted operand when subtracting
          ovf_d = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sum[NIBBLE_W-1]);
          state_d = S_DONE;
`ifdef CLA_SEQ_FLAGS_EN
          zero_d = res_d == '0;
          neg_d = res_d[WIDTH-1];
`endif
        end
      end
      S_DONE: state_d = bus.done_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef CLA_SEQ_FLAGS_EN
      zero_q <= 1'b0;
      neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
`ifdef CLA_SEQ_FLAGS_EN
      zero_q <= zero_d;
      neg_q <= neg_d;
`endif
    end
  end
  assign bus.start_ready = state_q == S_IDLE;
  assign bus.busy = state_q == S_RUN;
  assign bus.done_valid = state_q == S_DONE;
  assign bus.result = res_q;
  assign bus.cout = cout_q;
  assign bus.overflow = ovf_q;
`ifdef CLA_SEQ_FLAGS_EN
  assign bus.zero = zero_q;
  assign bus.neg = neg_q;
`endif
endmodule

// File: doc/cla_seq_ctrl.md
Name: cla_seq_ctrl

Overview:
Multi-cycle sequencer that performs WIDTH-bit add/subtract by reusing a single 4-bit carry-lookahead slice, one nibble per clock, least-significant nibble first. It captures operands through a valid/ready request handshake, chains the carry between nibbles in a register, and presents the result, carry and signed overflow through a valid/ready response handshake. It serves as the area-lean arithmetic path of the ALU, trading latency for adder area.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived localparam: number of slice passes.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start_valid  in  1  request valid.
start_ready  out  1  request ready; high only in IDLE.
a  in  WIDTH  operand A, sampled on request handshake.
b  in  WIDTH  operand B, sampled on request handshake.
sub  in  1  1 = A-B, 0 = A+B; sampled on request handshake.
busy  out  1  high in RUN.
result  out  WIDTH  sum/difference.
cout  out  1  final carry out; for subtract, 1 = no borrow.
overflow  out  1  signed two's-complement overflow.
done_valid  out  1  response valid.
done_ready  in  1  response accepted.

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE; idx=0; carry=0; result=0; cout=0; overflow=0; done_valid=0; busy=0; start_ready=1 once reset is released. The in-flight operation is discarded.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: a_reg<=a; b_reg<=b XOR {WIDTH{sub}}; carry<=sub; idx<=0; result<=0; go to RUN.
- RUN, one nibble per cycle:
  - Slice inputs: a_reg[4*idx+:4], b_reg[4*idx+:4], carry.
  - result[4*idx+:4]<=slice sum; carry<=slice Cout; idx<=idx+1.
  - start_valid is ignored.
  - On idx==NIBBLES-1: cout<=slice Cout; overflow<=a_reg[W-1] ~^ b_reg[W-1] AND (a_reg[W-1] ^ slice sum[3]), using the inverted B; go to DONE.
- DONE:
  - done_valid=1.
  - result, cout and overflow are held stable until done_valid&done_ready, then go to IDLE with done_valid=0.
  - No new request is accepted in the same cycle.
- Latency: done_valid rises NIBBLES cycles after the request handshake edge.
- Throughput: at most one operation per NIBBLES+2 cycles.
- Outputs are registered except start_ready and busy, which decode the state register.
- Any state encoding outside IDLE/RUN/DONE returns to IDLE on the next clock.
- idx width is clog2(NIBBLES), minimum 1. idx never wraps past NIBBLES-1.

Optional Feature:
Macro CLA_SEQ_FLAGS_EN.
- Defined: adds output ports zero (1 = result==0) and neg (result[W-1]). Both are registered, updated on entry to DONE, and cleared to 0 by reset.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package cla_seq_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NIBBLE_W=4 constant.
- Sub-module: one instance of the team's existing cla_4bit slice, named u_slice.
- Control FSM and nibble mux/demux stay in cla_seq_ctrl.

Test Plan:
- WIDTH=8, add 0x3C+0x5A: result=0x96, cout=0, overflow=1; done_valid exactly 2 cycles after handshake.
- WIDTH=8, sub 0x10-0x01: result=0x0F, cout=1, overflow=0. Then sub 0x01-0x02: result=0xFF, cout=0, overflow=0.
- WIDTH=8, add 0xFF+0x01: result=0x00, cout=1, overflow=0. With CLA_SEQ_FLAGS_EN: zero=1, neg=0.
- Backpressure: hold done_ready=0 for 5 cycles while start_valid=1 with new operands. Required: start_ready=0, outputs stable, second operation starts only after response handshake.
- Assert rst for 1 cycle mid-RUN (idx=1, WIDTH=16). Required: done_valid=0, result=0, start_ready=1 after release. A fresh 0xFFFF+0x0001 then gives result=0x0000, cout=1 after 4 cycles.
- WIDTH=4 (NIBBLES=1), add 0x7+0x1: result=0x8, overflow=1; done_valid 1 cycle after handshake.
